// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter sharing one adder between requesters

// Unsigned adder with carry out; the arbiter's only arithmetic resource.
module add #(
   parameter int DATA_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH:0]   sum_o
);

   assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// Grants one requester per cycle in round-robin order starting after the
// last winner, adds its operands and holds the sum in a one-entry output
// stage. A new result can load in the same cycle the old one drains.
module add_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_REQ    = 4,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_WIDTH:0]           res_data,
   output logic [ID_W-1:0]               res_id
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH:0]   res_data_q, res_data_d;
   logic [ID_W-1:0]       res_id_q, res_id_d;
   logic [ID_W-1:0]       last_grant_q, last_grant_d;

   logic                  can_accept;
   logic                  grant_found;
   logic [ID_W-1:0]       grant_idx;
   logic [ID_W-1:0]       scan_idx;
   logic                  transfer;
   logic [DATA_WIDTH-1:0] op_a, op_b;
   logic [DATA_WIDTH:0]   sum;

   // The output stage can take a new result when empty or draining now.
   assign can_accept = (state_q == EMPTY) || res_ready;

   // No transfer may complete while reset is held.
   assign transfer = grant_found && can_accept && !rst;

   // Round-robin scan: first valid requester after the last winner, with wrap.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Ready is one-hot on the winner and only when a transfer really happens.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = transfer && (grant_idx == ID_W'(i));
      end
   end

   // Operand mux into the shared adder; zero when nothing is granted.
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (transfer && (grant_idx == ID_W'(i))) begin
            op_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            op_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   add #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_add (
      .a_i   (op_a),
      .b_i   (op_b),
      .sum_o (sum)
   );

   // Next state: a transfer always reloads (covers drain+accept), otherwise a
   // drain empties the stage; data and id keep their last values when empty.
   always_comb begin
      state_d      = state_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      last_grant_d = last_grant_q;
      if (transfer) begin
         state_d      = FULL;
         res_data_d   = sum;
         res_id_d     = grant_idx;
         last_grant_d = grant_idx;
      end else if ((state_q == FULL) && res_ready) begin
         state_d = EMPTY;
      end
   end

   // Output stage and round-robin pointer; reset gives requester 0 priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         res_data_q   <= '0;
         res_id_q     <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid = (state_q == FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - randomized, model-checked bench for add_arbiter

module tb_add_arbiter;

   localparam int DW = 4;
   localparam int NR = 4;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a;
   logic [NR*DW-1:0]  req_b;
   logic              res_valid;
   logic              res_ready;
   logic [DW:0]       res_data;
   logic [IW-1:0]     res_id;

   int errors = 0;
   int checks = 0;

   // reference model state
   int  m_last;
   bit  m_valid;
   int  m_data;
   int  m_id;
   int  exp_grant;
   logic [NR-1:0] rdy_s;

   int order[6] = '{3, 0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   add_arbiter #(
      .DATA_WIDTH(DW),
      .NUM_REQ(NR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last  = NR - 1;
      m_valid = 1'b0;
      m_data  = 0;
      m_id    = 0;
   endtask

   // winner by the round-robin rule, or -1 when nothing may be accepted
   function automatic int pick();
      if (rst || (m_valid && !res_ready)) return -1;
      for (int k = 1; k <= NR; k++) begin
         if (req_valid[(m_last + k) % NR]) return (m_last + k) % NR;
      end
      return -1;
   endfunction

   task automatic offer(input int i, input int a, input int b);
      req_valid[i]         = 1'b1;
      req_a[i*DW +: DW]    = DW'(a);
      req_b[i*DW +: DW]    = DW'(b);
   endtask

   task automatic offer_rand(input int i);
      if ($urandom_range(0, 7) == 0) offer(i, 15, 15);
      else offer(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
   endtask

   // compare all outputs against the model mid-cycle
   task automatic settle();
      @(negedge clk);
      exp_grant = pick();
      check("req_ready", int'(req_ready), (exp_grant >= 0) ? (1 << exp_grant) : 0);
      check("res_valid", int'(res_valid), int'(m_valid));
      check("res_data", int'(res_data), m_data);
      check("res_id", int'(res_id), m_id);
      rdy_s = req_ready;
   endtask

   // clock edge: update model, then requesters retire accepted offers
   task automatic advance();
      @(posedge clk);
      if (exp_grant >= 0) begin
         m_data  = int'(req_a[exp_grant*DW +: DW]) + int'(req_b[exp_grant*DW +: DW]);
         m_id    = exp_grant;
         m_last  = exp_grant;
         m_valid = 1'b1;
      end else if (m_valid && res_ready) begin
         m_valid = 1'b0;
      end
      #1;
      for (int i = 0; i < NR; i++) begin
         if (rdy_s[i] && req_valid[i]) req_valid[i] = 1'b0;
      end
   endtask

   initial begin
      rst       = 1'b1;
      res_ready = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rdy_s     = '0;
      exp_grant = -1;
      model_reset();

      // reset with every requester valid
      for (int i = 0; i < NR; i++) offer_rand(i);
      settle();
      check("rst_ready", int'(req_ready), 0);
      check("rst_valid", int'(res_valid), 0);
      advance();
      rst = 1'b0;
      settle();
      check("first_grant", int'(req_ready), 1);
      advance();

      // single request with carry out
      req_valid = '0;
      offer(2, 15, 1);
      settle();
      check("carry_ready", int'(req_ready), 4);
      advance();
      settle();
      check("carry_valid", int'(res_valid), 1);
      check("carry_data", int'(res_data), 16);
      check("carry_id", int'(res_id), 2);
      advance();

      // round robin with all requesters continuously valid
      for (int i = 0; i < NR; i++) offer_rand(i);
      for (int k = 0; k < 6; k++) begin
         settle();
         check("rr_order", int'(req_ready), 1 << order[k]);
         if (k > 0) check("rr_throughput", int'(res_valid), 1);
         advance();
         for (int i = 0; i < NR; i++) if (!req_valid[i]) offer_rand(i);
      end

      // backpressure for five cycles, then drain and accept together
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         check("bp_ready", int'(req_ready), 0);
         check("bp_valid", int'(res_valid), 1);
         check("bp_id", int'(res_id), 0);
         advance();
      end
      res_ready = 1'b1;
      settle();
      check("bp_resume", int'(req_ready), 2);
      advance();
      settle();
      check("no_bubble_valid", int'(res_valid), 1);
      check("no_bubble_id", int'(res_id), 1);
      advance();

      // let the remaining offers finish, then only requesters 1 and 3
      for (int k = 0; k < 5; k++) begin
         settle();
         advance();
      end
      offer(1, 3, 4);
      settle();
      check("skip_first", int'(req_ready), 2);
      advance();
      offer(1, 5, 6);
      offer(3, 7, 9);
      settle();
      check("skip_to_3", int'(req_ready), 8);
      advance();
      offer(3, 1, 1);
      settle();
      check("skip_to_1", int'(req_ready), 2);
      check("skip_data", int'(res_data), 16);
      advance();
      offer(1, 2, 2);
      settle();
      check("skip_back_3", int'(req_ready), 8);
      advance();

      // reset while a result is held and requester 1 is pending
      res_ready = 1'b0;
      settle();
      advance();
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_async_valid", int'(res_valid), 0);
      offer(3, 4, 4);
      settle();
      check("rst_mid_ready", int'(req_ready), 0);
      advance();
      rst = 1'b0;
      res_ready = 1'b1;
      settle();
      check("post_rst_grant", int'(req_ready), 2);
      advance();

      // randomized traffic with occasional reset
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && ($urandom_range(0, 3) == 0)) offer_rand(i);
         end
         res_ready = ($urandom_range(0, 3) != 0);
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            model_reset();
         end
         settle();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
